// File: rtl/starfield_gen.sv
// Scrolling starfield background: per-row reseeded Galois LFSR stars, vertical scroll once per frame.
// Latency is 2 pix_en strobes for rgb and all syncs; there is no backpressure, and everything holds while pix_en is low.
module starfield_gen #(
  parameter int unsigned V_MAX       = 525,
  parameter logic [15:0] SEED        = 16'hACE1,
  parameter logic [8:0]  DENSITY     = 9'd6,
  parameter logic [9:0]  SCROLL_STEP = 10'd1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        pix_en,
  input  logic [9:0]  x,
  input  logic [9:0]  y,
  input  logic        hsync_in,
  input  logic        vsync_in,
  input  logic        video_on_in,
  input  logic        scroll_en,
  output logic [11:0] rgb,
  output logic        hsync_out,
  output logic        vsync_out,
  output logic        video_on_out
);

  localparam logic [10:0] VMAX11 = 11'(V_MAX);

  logic [15:0] lfsr_q, lfsr_d;
  logic        vid_prev_q, vid_prev_d, vs_prev_q, vs_prev_d;
  logic [5:0]  frame_cnt_q, frame_cnt_d;
  logic [9:0]  scroll_q, scroll_d;
  logic        hs_s1_q, hs_s1_d, vs_s1_q, vs_s1_d, vid_s1_q, vid_s1_d;
  logic        hs_s2_q, hs_s2_d, vs_s2_q, vs_s2_d, vid_s2_q, vid_s2_d;
  logic [11:0] rgb_q, rgb_d;

  logic [10:0] row_sum, scroll_sum;
  logic [9:0]  row, scroll_next;
  logic [15:0] seed_raw, seed, lfsr_step;
  logic        line_start, frame_ev, star;
  logic [11:0] colour;

  // Column is carried only for alignment with the timing block.
  logic unused_x;
  assign unused_x = ^x;

  always_comb begin
    row_sum     = {1'b0, y} + {1'b0, scroll_q};
    row         = (row_sum >= VMAX11) ? 10'(row_sum - VMAX11) : row_sum[9:0];
    scroll_sum  = {1'b0, scroll_q} + {1'b0, SCROLL_STEP};
    scroll_next = (scroll_sum >= VMAX11) ? 10'(scroll_sum - VMAX11) : scroll_sum[9:0];
    seed_raw    = SEED ^ {row, 6'h2A};
    seed        = (seed_raw == 16'h0000) ? 16'h0001 : seed_raw;
    lfsr_step   = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);
    line_start  = pix_en & video_on_in & ~vid_prev_q;
    frame_ev    = pix_en & vsync_in & ~vs_prev_q;
  end

  // Star colour is judged from the LFSR value that S1 produced for this pixel.
  always_comb begin
    star = vid_s1_q & ({1'b0, lfsr_q[7:0]} < DENSITY);
    case (lfsr_q[9:8])
      2'b00:   colour = 12'h444;
      2'b01:   colour = 12'h888;
      2'b10:   colour = 12'hCCC;
      default: colour = (frame_cnt_q[4] & lfsr_q[10]) ? 12'h888 : 12'hFFF;
    endcase
  end

  always_comb begin
    lfsr_d      = lfsr_q;
    vid_prev_d  = vid_prev_q;
    vs_prev_d   = vs_prev_q;
    frame_cnt_d = frame_cnt_q;
    scroll_d    = scroll_q;
    hs_s1_d     = hs_s1_q;
    vs_s1_d     = vs_s1_q;
    vid_s1_d    = vid_s1_q;
    hs_s2_d     = hs_s2_q;
    vs_s2_d     = vs_s2_q;
    vid_s2_d    = vid_s2_q;
    rgb_d       = rgb_q;
    if (pix_en) begin
      vid_prev_d = video_on_in;
      vs_prev_d  = vsync_in;
      hs_s1_d    = hsync_in;
      vs_s1_d    = vsync_in;
      vid_s1_d   = video_on_in;
      hs_s2_d    = hs_s1_q;
      vs_s2_d    = vs_s1_q;
      vid_s2_d   = vid_s1_q;
      rgb_d      = star ? colour : 12'h000;
      if (line_start) begin
        lfsr_d = seed;
      end else if (video_on_in) begin
        lfsr_d = lfsr_step;
      end
      // Row for this pixel was already formed from the pre-update scroll.
      if (frame_ev) begin
        frame_cnt_d = frame_cnt_q + 6'd1;
        if (scroll_en) begin
          scroll_d = scroll_next;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      lfsr_q      <= SEED;
      vid_prev_q  <= 1'b0;
      vs_prev_q   <= 1'b0;
      frame_cnt_q <= 6'd0;
      scroll_q    <= 10'd0;
      hs_s1_q     <= 1'b0;
      vs_s1_q     <= 1'b0;
      vid_s1_q    <= 1'b0;
      hs_s2_q     <= 1'b0;
      vs_s2_q     <= 1'b0;
      vid_s2_q    <= 1'b0;
      rgb_q       <= 12'h000;
    end else begin
      lfsr_q      <= lfsr_d;
      vid_prev_q  <= vid_prev_d;
      vs_prev_q   <= vs_prev_d;
      frame_cnt_q <= frame_cnt_d;
      scroll_q    <= scroll_d;
      hs_s1_q     <= hs_s1_d;
      vs_s1_q     <= vs_s1_d;
      vid_s1_q    <= vid_s1_d;
      hs_s2_q     <= hs_s2_d;
      vs_s2_q     <= vs_s2_d;
      vid_s2_q    <= vid_s2_d;
      rgb_q       <= rgb_d;
    end
  end

  assign rgb          = rgb_q;
  assign hsync_out    = hs_s2_q;
  assign vsync_out    = vs_s2_q;
  assign video_on_out = vid_s2_q;

endmodule

// File: tb/tb_starfield_gen.sv
// Scoreboard bench for starfield_gen: three density variants share one stimulus stream.
module tb_starfield_gen;

  localparam logic [15:0] SEED = 16'hACE1;

  logic       clk = 1'b0;
  logic       reset_n = 1'b1;
  logic       pix_en = 1'b0;
  logic [9:0] x = '0;
  logic [9:0] y = '0;
  logic       hsync_in = 1'b0, vsync_in = 1'b0, video_on_in = 1'b0, scroll_en = 1'b0;

  logic [11:0] rgb6, rgb0, rgb256;
  logic        hs6, vs6, vid6, hs0, vs0, vid0, hs256, vs256, vid256;

  always #5 clk = ~clk;

  starfield_gen dut (
    .clk(clk), .reset_n(reset_n), .pix_en(pix_en), .x(x), .y(y),
    .hsync_in(hsync_in), .vsync_in(vsync_in), .video_on_in(video_on_in), .scroll_en(scroll_en),
    .rgb(rgb6), .hsync_out(hs6), .vsync_out(vs6), .video_on_out(vid6));

  starfield_gen #(.DENSITY(9'd0)) dut_d0 (
    .clk(clk), .reset_n(reset_n), .pix_en(pix_en), .x(x), .y(y),
    .hsync_in(hsync_in), .vsync_in(vsync_in), .video_on_in(video_on_in), .scroll_en(scroll_en),
    .rgb(rgb0), .hsync_out(hs0), .vsync_out(vs0), .video_on_out(vid0));

  starfield_gen #(.DENSITY(9'd256)) dut_d256 (
    .clk(clk), .reset_n(reset_n), .pix_en(pix_en), .x(x), .y(y),
    .hsync_in(hsync_in), .vsync_in(vsync_in), .video_on_in(video_on_in), .scroll_en(scroll_en),
    .rgb(rgb256), .hsync_out(hs256), .vsync_out(vs256), .video_on_out(vid256));

  typedef struct {
    logic        hs, vs, vid;
    logic [11:0] rgb6, rgb0, rgb256;
    int          tag;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  logic [11:0] cap [0:31];
  int          errors = 0;
  int          checks = 0;

  logic [15:0] m_lfsr;
  logic        m_vid_prev, m_vs_prev;
  logic [5:0]  m_fc;
  int          m_scroll;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp_v, $time);
    end
  endtask

  task automatic m_reset();
    m_lfsr = SEED; m_vid_prev = 1'b0; m_vs_prev = 1'b0; m_fc = 6'd0; m_scroll = 0;
  endtask

  function automatic logic [11:0] colour(input logic [15:0] l, input logic [5:0] fc,
                                         input logic vid, input int dens);
    if (!vid || int'(l[7:0]) >= dens) return 12'h000;
    case (l[9:8])
      2'b00:   return 12'h444;
      2'b01:   return 12'h888;
      2'b10:   return 12'hCCC;
      default: return (fc[4] && l[10]) ? 12'h888 : 12'hFFF;
    endcase
  endfunction

  // Present one pixel, predict its output, and push the prediction.
  task automatic pix(input logic [9:0] yy, input logic hs, input logic vs, input logic vid,
                     input int gap, input int tag);
    int          row;
    logic [15:0] s;
    exp_t        e;
    x = x + 10'd1; y = yy; hsync_in = hs; vsync_in = vs; video_on_in = vid; pix_en = 1'b1;
    row = (int'(yy) + m_scroll) % 525;
    if (vid && !m_vid_prev) begin
      s = SEED ^ {row[9:0], 6'h2A};
      m_lfsr = (s == 16'h0000) ? 16'h0001 : s;
    end else if (vid) begin
      m_lfsr = {1'b0, m_lfsr[15:1]} ^ (m_lfsr[0] ? 16'hB400 : 16'h0000);
    end
    if (vs && !m_vs_prev) begin
      m_fc = m_fc + 6'd1;
      if (scroll_en) m_scroll = (m_scroll + 1) % 525;
    end
    m_vs_prev = vs; m_vid_prev = vid;
    e.hs = hs; e.vs = vs; e.vid = vid; e.tag = tag;
    e.rgb6 = colour(m_lfsr, m_fc, vid, 6);
    e.rgb0 = colour(m_lfsr, m_fc, vid, 0);
    e.rgb256 = colour(m_lfsr, m_fc, vid, 256);
    sb.push_back(e);
    @(negedge clk);
    pix_en = 1'b0;
    repeat (gap - 1) @(negedge clk);
  endtask

  task automatic line(input logic [9:0] yy, input int n, input int gap, input int tag_base);
    for (int i = 0; i < n; i++) pix(yy, 1'b0, 1'b0, 1'b1, gap, (tag_base < 0) ? -1 : tag_base + i);
    pix(yy, 1'b0, 1'b0, 1'b0, gap, -1);
    pix(yy, 1'b0, 1'b0, 1'b0, gap, -1);
  endtask

  task automatic vs_pulse(input int gap);
    pix(10'd0, 1'b0, 1'b1, 1'b0, gap, -1);
    pix(10'd0, 1'b0, 1'b0, 1'b0, gap, -1);
  endtask

  // Outputs of a pixel appear one strobe after the next one is issued.
  always @(posedge clk) begin
    if (pix_en && reset_n) begin
      #1;
      if (sb.size() >= 2) begin
        mon_e = sb.pop_front();
        chk("hsync_out", hs6, mon_e.hs);
        chk("vsync_out", vs6, mon_e.vs);
        chk("video_on_out", vid6, mon_e.vid);
        chk("rgb_d6", rgb6, mon_e.rgb6);
        chk("rgb_d0", rgb0, mon_e.rgb0);
        chk("rgb_d256", rgb256, mon_e.rgb256);
        chk("d256_star_iff_vid", rgb256 != 12'h000, mon_e.vid);
        if (mon_e.tag >= 0) cap[mon_e.tag] = rgb6;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    m_reset();
    #2 reset_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_rgb", rgb6, 12'h000);
    chk("reset_syncs", {hs6, vs6, vid6}, 3'b000);
    chk("reset_lfsr", dut.lfsr_q, 16'hACE1);
    chk("reset_scroll", dut.scroll_q, 10'd0);
    chk("reset_frame_cnt", dut.frame_cnt_q, 6'd0);
    reset_n = 1'b1;
    @(negedge clk);

    // Latency: pix_en every 4 clocks, 1-pixel hsync pulse.
    pix(10'd0, 1'b0, 1'b0, 1'b0, 4, -1);
    pix(10'd0, 1'b1, 1'b0, 1'b0, 4, -1);
    chk("hs_lat_s1", hs6, 1'b0);
    pix(10'd0, 1'b0, 1'b0, 1'b0, 4, -1);
    chk("hs_lat_s2", hs6, 1'b1);
    pix(10'd0, 1'b0, 1'b0, 1'b0, 4, -1);
    chk("hs_width", hs6, 1'b0);
    repeat (2) pix(10'd0, 1'b0, 1'b0, 1'b0, 4, -1);

    // Two frozen frames must repeat exactly; row 10 seed is hand-computed.
    scroll_en = 1'b0;
    for (int f = 0; f < 2; f++) begin
      vs_pulse(1);
      line(10'd9, 8, 1, -1);
      for (int i = 0; i < 8; i++) begin
        pix(10'd10, 1'b0, 1'b0, 1'b1, 1, f * 8 + i);
        if (f == 0 && i == 0) chk("row10_seed", dut.lfsr_q, 16'hAE4B);
        if (f == 0 && i == 1) chk("row10_step1", dut.lfsr_q, 16'hE325);
      end
      pix(10'd10, 1'b0, 1'b0, 1'b0, 1, -1);
      pix(10'd10, 1'b0, 1'b0, 1'b0, 1, -1);
      line(10'd11, 8, 1, -1);
    end
    for (int i = 0; i < 8; i++) chk("repeat_frame", cap[8 + i], cap[i]);

    // Scroll by one row per frame for 525 frames.
    scroll_en = 1'b1;
    for (int i = 0; i < 525; i++) begin
      vs_pulse(1);
      if (i == 0) chk("scroll_first", dut.scroll_q, 10'd1);
      line((i == 1) ? 10'd19 : 10'd20, 8, 1, (i < 2) ? 16 + 8 * i : -1);
    end
    chk("scroll_wrap", dut.scroll_q, 10'd0);
    for (int i = 0; i < 8; i++) chk("scroll_shift", cap[24 + i], cap[16 + i]);

    // Pause: scroll frozen while frame_cnt crosses 16 (twinkle flips).
    scroll_en = 1'b0;
    chk("fc_before_pause", dut.frame_cnt_q, 6'd15);
    for (int i = 0; i < 3; i++) begin
      vs_pulse(1);
      line(10'd5, 8, 1, -1);
    end
    chk("scroll_paused", dut.scroll_q, 10'd0);
    chk("fc_after_pause", dut.frame_cnt_q, 6'd18);

    // Asynchronous reset in the middle of a busy visible line.
    scroll_en = 1'b1;
    vs_pulse(2);
    vs_pulse(2);
    for (int i = 0; i < 3; i++) pix(10'd30, 1'b1, 1'b1, 1'b1, 2, -1);
    chk("scroll_before_rst", dut.scroll_q, 10'd3);
    @(posedge clk);
    #3;
    reset_n = 1'b0;
    sb.delete();
    m_reset();
    #1;
    chk("arst_rgb", rgb256, 12'h000);
    chk("arst_syncs", {hs6, vs6, vid6}, 3'b000);
    chk("arst_scroll", dut.scroll_q, 10'd0);
    chk("arst_lfsr", dut.lfsr_q, 16'hACE1);
    hsync_in = 1'b1; vsync_in = 1'b1; video_on_in = 1'b1;
    repeat (4) begin
      @(negedge clk);
      pix_en = ~pix_en;
    end
    chk("arst_hold_rgb", rgb256, 12'h000);
    chk("arst_hold_fc", dut.frame_cnt_q, 6'd0);
    @(negedge clk);
    pix_en = 1'b0; hsync_in = 1'b0; vsync_in = 1'b0; video_on_in = 1'b0;
    reset_n = 1'b1;
    @(negedge clk);
    vs_pulse(2);
    line(10'd40, 8, 2, -1);
    line(10'd524, 8, 2, -1);
    repeat (3) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
